spi_bus_arbiter: RTL and testbench
==================================

# spi_bus_arbiter

Shares the board's single SPI bus between the NIOSDuino core's SPI master and a hardware byte requester (e.g. an Ethernet polling engine). The block contains a mode-0 byte shifter for the hardware side and passes the core's SPI signals straight through while the core owns the bus. It sits between the NIOSDuino_Core `spi_*` pins and the FPGA SPI pins. Ownership changes only at transaction boundaries, with a guaranteed chip-select gap between owners.

## Interface
- CLK_DIV, 4, clk cycles per SCLK half-period for hardware transfers (≥1)
- GAP_CYCLES, 2, minimum cycles spi_ss_n is held high between owners (≥1)
- clk_in_clk  in  1  single clock; the NIOSDuino core runs on the same clock
- reset_reset_n  in  1  reset, synchronous and active-low
- core_ss_n, core_sclk, core_mosi  in  1 each  from core spi_SS_n/SCLK/MOSI
- core_miso  out  1  to core spi_MISO
- core_wait  out  1  core_ss_n low while the core is not the owner (routed to pi_export)
- hw_req  in  1  hardware requester wants the bus; held for the whole transaction
- hw_gnt  out  1  bus owned by the hardware requester
- hw_tx_data  in  8; hw_tx_valid  in  1; hw_tx_ready  out  1  byte input handshake
- hw_rx_data  out  8; hw_rx_valid  out  1  received byte with a 1-cycle strobe
- spi_ss_n, spi_sclk, spi_mosi  out  1 each; spi_miso  in  1  physical bus
- owner  out  2  00 none, 01 core, 10 hw

## Operation
- States: IDLE, CORE, HW_SEL, HW_HOLD, HW_SHIFT, GAP.
- IDLE: spi_ss_n=1, spi_sclk=0. A request is core_ss_n==0 or hw_req==1.
  - One requester active: grant it.
  - Both active: grant the one that did not own the bus last. `last` resets to hw, so the core wins the first tie.
- CORE: spi_ss_n/sclk/mosi = core_ss_n/sclk/mosi and core_miso=spi_miso, muxed combinationally on the registered owner. When core_ss_n is sampled high, go to GAP.
- core_miso=0 whenever owner≠core. core_wait is combinational. The core must hold SS low for ≥2 clk cycles before its first SCLK edge; software checks core_wait first.
- HW_SEL: spi_ss_n=0, hw_gnt=1. Stay CLK_DIV cycles (SS setup), then go to HW_HOLD.
- HW_HOLD: hw_tx_ready = hw_req.
  - tx_valid && tx_ready: latch the byte and go to HW_SHIFT.
  - hw_req==0: go to GAP. Release wins; ready is low, so no byte is accepted.
- HW_SHIFT: mode 0, MSB first.
  - Per bit: drive MOSI, wait CLK_DIV cycles, raise SCLK and sample MISO, wait CLK_DIV cycles, lower SCLK.
  - After bit 0: hw_rx_valid pulses for 1 cycle with hw_rx_data, then return to HW_HOLD.
  - If hw_req drops mid-byte, the byte completes and the release happens from HW_HOLD.
- GAP: spi_ss_n=1, sclk=0, hw_gnt=0, owner=00. Stay GAP_CYCLES cycles, then go to IDLE and update `last`.
- Arithmetic:
  - Divider counter is clog2(CLK_DIV+1) bits and wraps to 0 at CLK_DIV-1.
  - Bit counter is 3 bits and counts 7→0.
  - No overflow is possible.

## Timing
- Reset (sampled low at a clock edge) forces, at that edge:
  - state=IDLE
  - spi_ss_n=1, spi_sclk=0, spi_mosi=0
  - hw_gnt=0, hw_tx_ready=0, hw_rx_valid=0, hw_rx_data=0
  - owner=00, core_miso=0, last=hw
- Reset mid-transfer aborts with no rx_valid.
- Grant latency: request sampled in IDLE → owner/hw_gnt set 1 cycle later.
- Hardware byte: tx accept edge → first SCLK rise after CLK_DIV cycles. The byte takes 16·CLK_DIV cycles; hw_rx_valid fires 16·CLK_DIV+1 cycles after accept.
- Back-to-back bytes: tx_ready returns on the cycle after rx_valid, so SS stays low across bytes.
- Owner switch: spi_ss_n is high for exactly GAP_CYCLES+1 cycles (GAP plus the IDLE decision cycle) when the other side is already waiting.

## Structure
- Package spi_arb_pkg holds the state enum, the owner encoding (OWN_NONE/OWN_CORE/OWN_HW), and the default CLK_DIV/GAP_CYCLES constants.
- Sub-module spi_byte_shifter implements the mode-0 byte engine: start/byte in, sclk/mosi out, miso in, done/rx byte out, parameterised by CLK_DIV. The arbiter FSM and pass-through mux stay in the top module.

## Test plan
- Core only: core_ss_n low, 8 SCLK pulses of 0xA5 with MISO model returning 0x3C → spi pins mirror core pins, core_miso shows 0x3C, owner=01, core_wait=0.
- HW single byte, CLK_DIV=4: send 0x81, slave returns 0x7E → spi_ss_n low 4 cycles before the first SCLK, 8 SCLK pulses at 8-cycle period, hw_rx_data=0x7E pulsing 65 cycles after accept, then SS high for GAP.
- HW burst 0x01,0x02,0x03 with hw_req held → spi_ss_n stays low across all three bytes, three rx_valid pulses, release only after hw_req drops.
- Simultaneous hw_req and core_ss_n from reset → core granted first, core_wait=0. After core SS rises: 3 cycles SS high (GAP=2), then hw_gnt=1. Second tie → hw wins.
- Core asserts SS during a hw burst → core_wait=1, core_miso=0, spi pins unaffected. Core gets the bus after the hw release plus gap.
- reset_reset_n low mid-byte → next edge: spi_ss_n=1, sclk=0, hw_gnt=0, no rx_valid. After reset, a fresh transfer completes normally.

Source files
------------

// File: rtl/spi_bus_arbiter_pkg.sv
// Shared types and defaults for the SPI bus arbiter: FSM states, owner codes,
// and default timing constants.
package spi_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CORE,
        S_HW_SEL,
        S_HW_HOLD,
        S_HW_SHIFT,
        S_GAP
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_CORE = 2'b01,
        OWN_HW   = 2'b10
    } owner_t;

    localparam int DEF_CLK_DIV    = 4;
    localparam int DEF_GAP_CYCLES = 2;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_bus_arbiter_if.sv
// Hardware requester handshake: bus request/grant plus byte-level tx/rx streams.
interface spi_bus_arbiter_if;
    logic       hw_req;
    logic       hw_gnt;
    logic [7:0] hw_tx_data;
    logic       hw_tx_valid;
    logic       hw_tx_ready;
    logic [7:0] hw_rx_data;
    logic       hw_rx_valid;

    modport master (
        output hw_req, hw_tx_data, hw_tx_valid,
        input  hw_gnt, hw_tx_ready, hw_rx_data, hw_rx_valid
    );

    modport slave (
        input  hw_req, hw_tx_data, hw_tx_valid,
        output hw_gnt, hw_tx_ready, hw_rx_data, hw_rx_valid
    );
endinterface

// File: rtl/spi_bus_arbiter_shifter.sv
// Mode-0 MSB-first byte engine: MOSI changes on SCLK fall, MISO sampled on rise,
// each SCLK half-period lasting CLK_DIV clocks.
module spi_byte_shifter
    import spi_arb_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic [7:0] byte_i,
    input  logic       miso_i,
    output logic       sclk_o,
    output logic       mosi_o,
    output logic       done_o,
    output logic [7:0] rx_o
);
    localparam int DIV_W = $clog2(CLK_DIV + 1);

    logic             busy_q;
    logic             sclk_q;
    logic             done_q;
    logic [DIV_W-1:0] div_q;
    logic [2:0]       bit_q;
    logic [7:0]       sh_q;
    logic [7:0]       rx_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            busy_q <= 1'b0;
            sclk_q <= 1'b0;
            done_q <= 1'b0;
            div_q  <= '0;
            bit_q  <= 3'd7;
            sh_q   <= 8'h00;
            rx_q   <= 8'h00;
        end else begin
            done_q <= 1'b0;
            if (start_i && !busy_q) begin
                busy_q <= 1'b1;
                sh_q   <= byte_i;
                div_q  <= '0;
                bit_q  <= 3'd7;
                sclk_q <= 1'b0;
            end else if (busy_q) begin
                if (div_q == DIV_W'(CLK_DIV - 1)) begin
                    div_q <= '0;
                    if (!sclk_q) begin
                        sclk_q <= 1'b1;
                        rx_q   <= {rx_q[6:0], miso_i};
                    end else begin
                        sclk_q <= 1'b0;
                        // Last bit leaves MOSI where it is; nothing listens after the fall.
                        if (bit_q == 3'd0) begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            bit_q <= bit_q - 3'd1;
                            sh_q  <= {sh_q[6:0], 1'b0};
                        end
                    end
                end else begin
                    div_q <= div_q + 1'b1;
                end
            end
        end
    end

    assign sclk_o = sclk_q;
    assign mosi_o = sh_q[7];
    assign done_o = done_q;
    assign rx_o   = rx_q;

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one SPI bus between the core's SPI master (pass-through) and a hardware
// byte requester, switching owners only between transactions with an SS-high gap.
module spi_bus_arbiter
    import spi_arb_pkg::*;
#(
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic                 clk_in_clk,
    input  logic                 reset_reset_n,
    input  logic                 core_ss_n,
    input  logic                 core_sclk,
    input  logic                 core_mosi,
    output logic                 core_miso,
    output logic                 core_wait,
    spi_bus_arbiter_if.slave     hw,
    output logic                 spi_ss_n,
    output logic                 spi_sclk,
    output logic                 spi_mosi,
    input  logic                 spi_miso,
    output logic [1:0]           owner
);
    localparam int CNT_W = $clog2(max2(CLK_DIV, GAP_CYCLES) + 1);

    state_t           state_q;
    owner_t           owner_q, last_q, gap_own_q;
    logic             gnt_q, ss_q, rx_valid_q;
    logic [7:0]       rx_data_q;
    logic [CNT_W-1:0] cnt_q;

    logic       shf_start, shf_sclk, shf_mosi, shf_done;
    logic [7:0] shf_rx;
    logic       core_req;

    assign core_req  = ~core_ss_n;
    assign shf_start = (state_q == S_HW_HOLD) && hw.hw_req && hw.hw_tx_valid;

    spi_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
        .clk_i   (clk_in_clk),
        .rst_ni  (reset_reset_n),
        .start_i (shf_start),
        .byte_i  (hw.hw_tx_data),
        .miso_i  (spi_miso),
        .sclk_o  (shf_sclk),
        .mosi_o  (shf_mosi),
        .done_o  (shf_done),
        .rx_o    (shf_rx)
    );

    always_ff @(posedge clk_in_clk) begin
        if (!reset_reset_n) begin
            state_q    <= S_IDLE;
            owner_q    <= OWN_NONE;
            last_q     <= OWN_HW;
            gap_own_q  <= OWN_HW;
            gnt_q      <= 1'b0;
            ss_q       <= 1'b1;
            cnt_q      <= '0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'h00;
        end else begin
            rx_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    // On a tie the side that did not own the bus last goes first.
                    if (core_req && (!hw.hw_req || last_q == OWN_HW)) begin
                        state_q <= S_CORE;
                        owner_q <= OWN_CORE;
                    end else if (hw.hw_req) begin
                        state_q <= S_HW_SEL;
                        owner_q <= OWN_HW;
                        gnt_q   <= 1'b1;
                        ss_q    <= 1'b0;
                    end
                end
                S_CORE: begin
                    if (core_ss_n) begin
                        state_q   <= S_GAP;
                        owner_q   <= OWN_NONE;
                        gap_own_q <= OWN_CORE;
                        cnt_q     <= '0;
                    end
                end
                S_HW_SEL: begin
                    if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                        state_q <= S_HW_HOLD;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_HW_HOLD: begin
                    if (hw.hw_req && hw.hw_tx_valid) begin
                        state_q <= S_HW_SHIFT;
                    end else if (!hw.hw_req) begin
                        state_q   <= S_GAP;
                        owner_q   <= OWN_NONE;
                        gnt_q     <= 1'b0;
                        ss_q      <= 1'b1;
                        gap_own_q <= OWN_HW;
                        cnt_q     <= '0;
                    end
                end
                S_HW_SHIFT: begin
                    // Hold one extra cycle so tx_ready reopens after the rx strobe.
                    if (rx_valid_q) begin
                        state_q <= S_HW_HOLD;
                    end else if (shf_done) begin
                        rx_valid_q <= 1'b1;
                        rx_data_q  <= shf_rx;
                    end
                end
                S_GAP: begin
                    if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                        state_q <= S_IDLE;
                        last_q  <= gap_own_q;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign spi_ss_n  = (owner_q == OWN_CORE) ? core_ss_n : ss_q;
    assign spi_sclk  = (owner_q == OWN_CORE) ? core_sclk : shf_sclk;
    assign spi_mosi  = (owner_q == OWN_CORE) ? core_mosi : shf_mosi;
    assign core_miso = (owner_q == OWN_CORE) ? spi_miso : 1'b0;
    assign core_wait = core_req && (owner_q != OWN_CORE);
    assign owner     = owner_q;

    assign hw.hw_gnt      = gnt_q;
    assign hw.hw_tx_ready = (state_q == S_HW_HOLD) && hw.hw_req;
    assign hw.hw_rx_valid = rx_valid_q;
    assign hw.hw_rx_data  = rx_data_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Bench for spi_bus_arbiter: mode-0 slave model on the SPI pins, randomized bytes,
// and a simple ownership model for arbitration ties.
module tb_spi_bus_arbiter;
    localparam int CD       = 4;
    localparam int GAP      = 2;
    localparam int BYTE_LAT = 16 * CD + 1;
    localparam logic [1:0] M_NONE = 2'b00, M_CORE = 2'b01, M_HW = 2'b10;

    logic clk = 1'b0, rst_n = 1'b0;
    logic core_ss_n = 1'b1, core_sclk = 1'b0, core_mosi = 1'b0;
    logic core_miso, core_wait, spi_ss_n, spi_sclk, spi_mosi, spi_miso;
    logic [1:0] owner;

    spi_bus_arbiter_if hw_if ();

    spi_bus_arbiter #(.CLK_DIV(CD), .GAP_CYCLES(GAP)) dut (
        .clk_in_clk    (clk),
        .reset_reset_n (rst_n),
        .core_ss_n     (core_ss_n),
        .core_sclk     (core_sclk),
        .core_mosi     (core_mosi),
        .core_miso     (core_miso),
        .core_wait     (core_wait),
        .hw            (hw_if),
        .spi_ss_n      (spi_ss_n),
        .spi_sclk      (spi_sclk),
        .spi_mosi      (spi_mosi),
        .spi_miso      (spi_miso),
        .owner         (owner)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    logic [1:0] m_last;

    // Mode-0 slave: shifts its byte out MSB first, advancing on each SCLK fall.
    int         fall_cnt = 0;
    int         base = 0;
    int         s_idx;
    logic [7:0] slave_byte = 8'h00;
    logic [7:0] slave_rx = 8'h00;

    always @(negedge spi_sclk) fall_cnt <= fall_cnt + 1;
    always @(posedge spi_sclk) slave_rx <= {slave_rx[6:0], spi_mosi};

    always_comb begin
        spi_miso = 1'b0;
        s_idx    = 7 - (fall_cnt - base);
        if (!spi_ss_n && s_idx >= 0 && s_idx <= 7) spi_miso = slave_byte[s_idx[2:0]];
    end

    function automatic logic [1:0] winner(input logic c, input logic h, input logic [1:0] last);
        if (c && h) return (last == M_HW) ? M_CORE : M_HW;
        if (c) return M_CORE;
        if (h) return M_HW;
        return M_NONE;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst_n = 1'b0;
        hw_if.hw_req = 1'b0;
        hw_if.hw_tx_valid = 1'b0;
        core_ss_n = 1'b1;
        core_sclk = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        m_last = M_HW;
    endtask

    task automatic hw_acquire;
        hw_if.hw_req = 1'b1;
        for (int i = 0; i < 60 && !hw_if.hw_tx_ready; i++) tick;
    endtask

    task automatic wait_idle;
        for (int i = 0; i < GAP + CD + 4; i++) tick;
    endtask

    // Sends one byte and measures timing relative to the accept edge (k=0).
    task automatic do_hw_byte(input logic [7:0] tx, input logic [7:0] sl, output logic [7:0] rx,
                              output int t_rise, output int t_rv, output int pulses,
                              output int span, output bit ss_hi);
        int   last;
        logic prev;
        rx = 8'h00; t_rise = -1; t_rv = -1; pulses = 0; span = -1; ss_hi = 1'b0; last = -1;
        hw_if.hw_tx_data = tx;
        hw_if.hw_tx_valid = 1'b1;
        for (int i = 0; i < 100 && !hw_if.hw_tx_ready; i++) tick;
        if (!hw_if.hw_tx_ready) begin
            hw_if.hw_tx_valid = 1'b0;
            return;
        end
        slave_byte = sl;
        base = fall_cnt;
        tick;
        hw_if.hw_tx_valid = 1'b0;
        prev = 1'b0;
        for (int k = 1; k <= BYTE_LAT + 8; k++) begin
            tick;
            if (spi_ss_n) ss_hi = 1'b1;
            if (spi_sclk && !prev) begin
                pulses++;
                if (t_rise < 0) t_rise = k;
                last = k;
            end
            prev = spi_sclk;
            if (hw_if.hw_rx_valid) begin
                t_rv = k;
                rx = hw_if.hw_rx_data;
                break;
            end
        end
        span = last - t_rise;
    endtask

    task automatic test_reset;
        apply_reset;
        tick;
        n_cmp++; if (spi_ss_n !== 1'b1) begin n_err++; $display("FAIL reset_ss_n: got %b expected 1", spi_ss_n); end
        n_cmp++; if (spi_sclk !== 1'b0 || spi_mosi !== 1'b0) begin n_err++; $display("FAIL reset_sclk_mosi: got %b%b expected 00", spi_sclk, spi_mosi); end
        n_cmp++; if (hw_if.hw_gnt !== 1'b0 || hw_if.hw_tx_ready !== 1'b0 || hw_if.hw_rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_hw_flags: got %b%b%b expected 000", hw_if.hw_gnt, hw_if.hw_tx_ready, hw_if.hw_rx_valid); end
        n_cmp++; if (hw_if.hw_rx_data !== 8'h00) begin n_err++; $display("FAIL reset_rx_data: got %h expected 00", hw_if.hw_rx_data); end
        n_cmp++; if (owner !== M_NONE || core_miso !== 1'b0) begin n_err++; $display("FAIL reset_owner_miso: got %b/%b expected 00/0", owner, core_miso); end
    endtask

    task automatic test_core_only(input logic [7:0] mo, input logic [7:0] si);
        logic [7:0] rd;
        bit         mirror_ok;
        slave_byte = si;
        base = fall_cnt;
        core_ss_n = 1'b0;
        tick;
        n_cmp++; if (owner !== winner(1'b1, 1'b0, m_last)) begin n_err++; $display("FAIL core_grant: got %b expected %b", owner, M_CORE); end
        n_cmp++; if (core_wait !== 1'b0 || spi_ss_n !== 1'b0) begin n_err++; $display("FAIL core_wait_ss: got %b/%b expected 0/0", core_wait, spi_ss_n); end
        tick;
        tick;
        rd = 8'h00;
        mirror_ok = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            core_mosi = mo[i];
            tick;
            if (spi_mosi !== core_mosi || spi_sclk !== core_sclk || spi_ss_n !== 1'b0) mirror_ok = 1'b0;
            rd = {rd[6:0], core_miso};
            core_sclk = 1'b1;
            tick;
            if (spi_sclk !== 1'b1) mirror_ok = 1'b0;
            tick;
            core_sclk = 1'b0;
            tick;
        end
        n_cmp++; if (mirror_ok !== 1'b1) begin n_err++; $display("FAIL core_mirror: got %b expected 1", mirror_ok); end
        n_cmp++; if (rd !== si) begin n_err++; $display("FAIL core_miso_byte: got %h expected %h", rd, si); end
        n_cmp++; if (slave_rx !== mo) begin n_err++; $display("FAIL core_mosi_byte: got %h expected %h", slave_rx, mo); end
        core_mosi = 1'b0;
        core_ss_n = 1'b1;
        tick;
        n_cmp++; if (owner !== M_NONE || spi_ss_n !== 1'b1) begin n_err++; $display("FAIL core_release: got %b/%b expected 00/1", owner, spi_ss_n); end
        m_last = M_CORE;
        wait_idle;
    endtask

    task automatic test_hw_single(input logic [7:0] tx, input logic [7:0] sl);
        logic [7:0] rx;
        int tr, tv, np, sp, setup;
        bit sh;
        hw_if.hw_req = 1'b1;
        tick;
        n_cmp++; if (hw_if.hw_gnt !== 1'b1 || owner !== M_HW || spi_ss_n !== 1'b0) begin n_err++; $display("FAIL hw_grant: got %b/%b/%b expected 1/10/0", hw_if.hw_gnt, owner, spi_ss_n); end
        setup = 0;
        while (!hw_if.hw_tx_ready && setup < 50) begin tick; setup++; end
        n_cmp++; if (setup !== CD) begin n_err++; $display("FAIL hw_ss_setup: got %0d expected %0d", setup, CD); end
        do_hw_byte(tx, sl, rx, tr, tv, np, sp, sh);
        n_cmp++; if (rx !== sl) begin n_err++; $display("FAIL hw_rx_data: got %h expected %h", rx, sl); end
        n_cmp++; if (slave_rx !== tx) begin n_err++; $display("FAIL hw_mosi_byte: got %h expected %h", slave_rx, tx); end
        n_cmp++; if (tr !== CD) begin n_err++; $display("FAIL hw_first_rise: got %0d expected %0d", tr, CD); end
        n_cmp++; if (tv !== BYTE_LAT) begin n_err++; $display("FAIL hw_rx_latency: got %0d expected %0d", tv, BYTE_LAT); end
        n_cmp++; if (np !== 8 || sp !== 14 * CD) begin n_err++; $display("FAIL hw_sclk_pulses: got %0d/%0d expected 8/%0d", np, sp, 14 * CD); end
        n_cmp++; if (sh !== 1'b0) begin n_err++; $display("FAIL hw_ss_held: got %b expected 0", sh); end
        hw_if.hw_req = 1'b0;
        tick;
        n_cmp++; if (hw_if.hw_rx_valid !== 1'b0) begin n_err++; $display("FAIL hw_rx_pulse_width: got %b expected 0", hw_if.hw_rx_valid); end
        tick;
        n_cmp++; if (spi_ss_n !== 1'b1 || hw_if.hw_gnt !== 1'b0 || owner !== M_NONE) begin n_err++; $display("FAIL hw_release: got %b/%b/%b expected 1/0/00", spi_ss_n, hw_if.hw_gnt, owner); end
        m_last = M_HW;
        wait_idle;
    endtask

    task automatic test_burst;
        logic [7:0] txq[$];
        logic [7:0] rx, sl;
        int tr, tv, np, sp, n_rv;
        bit sh, ss_any;
        txq = '{8'h01, 8'h02, 8'h03};
        for (int i = 0; i < int'($urandom_range(2, 0)); i++) txq.push_back(8'($urandom));
        hw_acquire;
        n_rv = 0;
        ss_any = 1'b0;
        for (int i = 0; i < txq.size(); i++) begin
            sl = 8'($urandom);
            do_hw_byte(txq[i], sl, rx, tr, tv, np, sp, sh);
            if (sh) ss_any = 1'b1;
            if (tv == BYTE_LAT) n_rv++;
            n_cmp++; if (rx !== sl || slave_rx !== txq[i]) begin n_err++; $display("FAIL burst_byte%0d: got rx %h mosi %h expected %h %h", i, rx, slave_rx, sl, txq[i]); end
            n_cmp++; if (hw_if.hw_tx_ready !== 1'b0) begin n_err++; $display("FAIL burst_ready_low%0d: got %b expected 0", i, hw_if.hw_tx_ready); end
            tick;
            if (spi_ss_n) ss_any = 1'b1;
            n_cmp++; if (hw_if.hw_tx_ready !== 1'b1) begin n_err++; $display("FAIL burst_ready_back%0d: got %b expected 1", i, hw_if.hw_tx_ready); end
        end
        n_cmp++; if (n_rv !== txq.size()) begin n_err++; $display("FAIL burst_rx_count: got %0d expected %0d", n_rv, txq.size()); end
        for (int i = 0; i < 4; i++) begin
            tick;
            if (spi_ss_n || !hw_if.hw_gnt) ss_any = 1'b1;
        end
        n_cmp++; if (ss_any !== 1'b0) begin n_err++; $display("FAIL burst_ss_low: got %b expected 0", ss_any); end
        hw_if.hw_req = 1'b0;
        tick;
        n_cmp++; if (spi_ss_n !== 1'b1 || hw_if.hw_gnt !== 1'b0) begin n_err++; $display("FAIL burst_release: got %b/%b expected 1/0", spi_ss_n, hw_if.hw_gnt); end
        m_last = M_HW;
        wait_idle;
    endtask

    // Core SS rises, then re-asserts during the gap so the next IDLE decision is a tie.
    task automatic switch_with_retie(output bit gap_ok);
        gap_ok = 1'b1;
        core_ss_n = 1'b1;
        for (int j = 0; j <= GAP; j++) begin
            tick;
            if (j == 0) core_ss_n = 1'b0;
            if (spi_ss_n !== 1'b1 || hw_if.hw_gnt !== 1'b0) gap_ok = 1'b0;
        end
        tick;
    endtask

    task automatic test_tie;
        logic [1:0] exp;
        logic [7:0] rx, tx, sl;
        int tr, tv, np, sp;
        bit sh, gap_ok;
        apply_reset;
        hw_if.hw_req = 1'b1;
        core_ss_n = 1'b0;
        tick;
        exp = winner(1'b1, 1'b1, m_last);
        n_cmp++; if (owner !== exp || core_wait !== 1'b0 || hw_if.hw_gnt !== 1'b0) begin n_err++; $display("FAIL tie1_owner: got %b/%b/%b expected %b/0/0", owner, core_wait, hw_if.hw_gnt, exp); end
        m_last = exp;
        tick;
        tick;
        switch_with_retie(gap_ok);
        exp = winner(1'b1, 1'b1, m_last);
        n_cmp++; if (gap_ok !== 1'b1) begin n_err++; $display("FAIL tie2_gap: got %b expected 1", gap_ok); end
        n_cmp++; if (owner !== exp || hw_if.hw_gnt !== 1'b1 || spi_ss_n !== 1'b0) begin n_err++; $display("FAIL tie2_owner: got %b/%b/%b expected %b/1/0", owner, hw_if.hw_gnt, spi_ss_n, exp); end
        n_cmp++; if (core_wait !== 1'b1 || core_miso !== 1'b0) begin n_err++; $display("FAIL tie2_core_wait: got %b/%b expected 1/0", core_wait, core_miso); end
        m_last = exp;
        core_sclk = 1'b1;
        core_mosi = 1'b1;
        for (int b = 0; b < 2; b++) begin
            tx = 8'($urandom);
            sl = 8'($urandom);
            do_hw_byte(tx, sl, rx, tr, tv, np, sp, sh);
            n_cmp++; if (rx !== sl || slave_rx !== tx || np !== 8 || sh !== 1'b0) begin n_err++; $display("FAIL hw_vs_core_byte%0d: got %h/%h/%0d/%b expected %h/%h/8/0", b, rx, slave_rx, np, sh, sl, tx); end
            n_cmp++; if (core_wait !== 1'b1 || core_miso !== 1'b0) begin n_err++; $display("FAIL hw_vs_core_wait%0d: got %b/%b expected 1/0", b, core_wait, core_miso); end
        end
        core_sclk = 1'b0;
        core_mosi = 1'b0;
        hw_if.hw_req = 1'b0;
        tick;
        gap_ok = 1'b1;
        for (int j = 0; j <= GAP; j++) begin
            tick;
            if (spi_ss_n !== 1'b1) gap_ok = 1'b0;
        end
        tick;
        exp = winner(1'b1, 1'b0, m_last);
        n_cmp++; if (gap_ok !== 1'b1 || owner !== exp || core_wait !== 1'b0) begin n_err++; $display("FAIL core_after_hw: got %b/%b/%b expected 1/%b/0", gap_ok, owner, core_wait, exp); end
        m_last = exp;
        hw_if.hw_req = 1'b1;
        tick;
        switch_with_retie(gap_ok);
        exp = winner(1'b1, 1'b1, m_last);
        n_cmp++; if (gap_ok !== 1'b1 || owner !== exp) begin n_err++; $display("FAIL tie3_owner: got %b/%b expected 1/%b", gap_ok, owner, exp); end
        m_last = exp;
        core_ss_n = 1'b1;
        hw_if.hw_req = 1'b0;
        wait_idle;
    endtask

    task automatic test_reset_mid;
        logic [7:0] rx, tx, sl;
        int tr, tv, np, sp;
        bit sh, rv_seen;
        hw_acquire;
        slave_byte = 8'($urandom);
        base = fall_cnt;
        hw_if.hw_tx_data = 8'($urandom);
        hw_if.hw_tx_valid = 1'b1;
        tick;
        hw_if.hw_tx_valid = 1'b0;
        for (int i = 0; i < 3 * CD + 1; i++) tick;
        rst_n = 1'b0;
        hw_if.hw_req = 1'b0;
        tick;
        n_cmp++; if (spi_ss_n !== 1'b1 || spi_sclk !== 1'b0 || hw_if.hw_gnt !== 1'b0 || owner !== M_NONE) begin n_err++; $display("FAIL reset_mid_bus: got %b/%b/%b/%b expected 1/0/0/00", spi_ss_n, spi_sclk, hw_if.hw_gnt, owner); end
        rst_n = 1'b1;
        m_last = M_HW;
        rv_seen = 1'b0;
        for (int i = 0; i < 20 * CD; i++) begin
            if (hw_if.hw_rx_valid) rv_seen = 1'b1;
            tick;
        end
        n_cmp++; if (rv_seen !== 1'b0) begin n_err++; $display("FAIL reset_mid_no_rx: got %b expected 0", rv_seen); end
        hw_acquire;
        tx = 8'($urandom);
        sl = 8'($urandom);
        do_hw_byte(tx, sl, rx, tr, tv, np, sp, sh);
        n_cmp++; if (rx !== sl || slave_rx !== tx || tv !== BYTE_LAT) begin n_err++; $display("FAIL reset_mid_fresh: got %h/%h/%0d expected %h/%h/%0d", rx, slave_rx, tv, sl, tx, BYTE_LAT); end
        hw_if.hw_req = 1'b0;
        wait_idle;
    endtask

    initial begin
        hw_if.hw_req = 1'b0;
        hw_if.hw_tx_valid = 1'b0;
        hw_if.hw_tx_data = 8'h00;
        m_last = M_HW;
        test_reset;
        test_core_only(8'hA5, 8'h3C);
        test_core_only(8'($urandom), 8'($urandom));
        test_hw_single(8'h81, 8'h7E);
        for (int i = 0; i < 3; i++) test_hw_single(8'($urandom), 8'($urandom));
        test_burst;
        test_tie;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

endmodule
